stack_mem_responder: RTL and testbench
======================================

Name: stack_mem_responder

Overview:
- Memory-side responder for the stack-calculator controller. It owns the 128x8 stack RAM and the stack pointer.
- It executes push, pop, peek, indexed-read and clear commands issued over a valid/ready command channel.
- It returns one response pulse per command.
- It replaces the controller's direct RAM/SPR manipulation, so the controller only sequences commands and drives the display/LEDs.

Parameters:
- DW, 8, data width.
- DEPTH, 128, number of stack entries (power of two).
- AW, 7, address width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  responder can accept a command (high only in IDLE).
- cmd_op  in  3  0=PUSH, 1=POP, 2=PEEK, 3=READ_AT, 4=CLEAR; 5-7 reserved.
- cmd_addr  in  AW  address for READ_AT.
- cmd_wdata  in  DW  data for PUSH.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_data  out  DW  response data, valid when rsp_valid is high.
- rsp_err  out  1  command failed, valid when rsp_valid is high.
- sp  out  AW  next free address; top of stack is at sp+1.
- count  out  AW+1  number of occupied entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset values:
  - State IDLE.
  - sp=DEPTH-1 (7'h7F), count=0, empty=1, full=0.
  - cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0.
  - RAM contents are not initialised by reset.
- Stack grows downward:
  - PUSH writes RAM[sp], then sp<=sp-1 and count<=count+1.
  - POP reads RAM[sp+1], then sp<=sp+1 and count<=count-1.
  - Pointer arithmetic is modulo DEPTH. count prevents aliasing, so wrap only occurs at the legal full or empty boundary.
- Handshake:
  - A command is accepted on any cycle where cmd_valid && cmd_ready. cmd_op, cmd_addr and cmd_wdata are latched on acceptance.
  - cmd_ready is low from the cycle after acceptance until the state returns to IDLE.
  - There is no response backpressure; rsp_valid is a single-cycle pulse.
- FSM states: IDLE, EXEC, RESP (plus SCRUB when the optional feature is compiled in).
  - IDLE -> EXEC on acceptance.
  - EXEC issues the RAM access: write for PUSH, synchronous read for POP/PEEK/READ_AT. It also updates sp and count.
  - EXEC -> RESP unconditionally.
  - In RESP: rsp_valid=1 and rsp_data = RAM read data (0 for PUSH/CLEAR). RESP -> IDLE.
- Latency: command accepted at cycle N, rsp_valid at cycle N+2, next acceptance possible at N+3.
- RAM timing: synchronous read with one-cycle latency, read-first. No operation reads and writes the same cycle.
- Boundary conditions:
  - PUSH when full: no write, sp and count unchanged, rsp_err=1, rsp_data=0.
  - POP or PEEK when empty: no pointer change, rsp_err=1, rsp_data=0.
  - PEEK: reads RAM[sp+1], no pointer change.
  - READ_AT: reads RAM[cmd_addr] regardless of occupancy; rsp_err=0.
  - CLEAR: sp<=DEPTH-1, count<=0, RAM untouched, rsp_err=0.
  - Reserved op: no state change, rsp_err=1, rsp_data=0.
- empty, full and count are registered and update in the cycle after EXEC. They are always consistent with sp.
- Reset mid-operation (any state): return to IDLE with reset values next cycle. Any pending response is dropped, and an EXEC write already issued that cycle is suppressed.
- cmd_valid asserted while cmd_ready is low is ignored. The command is neither latched nor lost to the initiator, which must hold it.

Optional Feature:
- Macro: STACK_SCRUB_EN.
- Defined:
  - CLEAR enters SCRUB after EXEC and writes 0 to RAM[0..DEPTH-1], one address per cycle.
  - It then goes to RESP, so CLEAR latency is DEPTH+2 cycles from acceptance.
  - cmd_ready stays low throughout.
  - Reset during SCRUB aborts the scrub.
- Undefined: the SCRUB state does not exist and CLEAR completes in 2 cycles with RAM untouched.

Decomposition:
- Package stack_pkg:
  - Op-code localparams OP_PUSH..OP_CLEAR.
  - FSM state encoding.
  - Default DW/DEPTH/AW constants shared with the controller.
- Sub-module stack_ram:
  - Single-port synchronous RAM with DW/AW parameters; ports clk, we, addr, wdata, rdata.
  - Read-first; no reset.

Test Plan:
- After reset: push 8'h11, 8'h22, 8'h33 -> each rsp_err=0, count=3, sp=7'h7C. Then PEEK -> rsp_data=8'h33, and rsp_valid exactly 2 cycles after acceptance.
- Pop three times -> rsp_data 8'h33, 8'h22, 8'h11, then empty=1 and sp=7'h7F. A fourth pop -> rsp_err=1, rsp_data=0, count stays 0.
- Push 128 values (i=0..127) -> full=1, count=128. Push 8'hAA -> rsp_err=1. READ_AT addr 0 -> 8'd127 (last pushed); READ_AT addr 7'h7F -> 8'd0.
- Push 8'h55, then CLEAR -> count=0, empty=1. READ_AT 7'h7F returns 8'h55 without STACK_SCRUB_EN, and 8'h00 with it. Check CLEAR latency is 2 cycles without the macro and 130 cycles with it.
- Hold cmd_valid high with back-to-back PUSH ops -> accepted only every 3rd cycle, and no command is dropped or duplicated.
- Assert reset in the EXEC cycle of a PUSH at count=2 -> next cycle state IDLE, count=0, sp=7'h7F, no rsp_valid. The target RAM word is unchanged.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack memory responder and the stack-calculator
// controller: default geometry, command op-codes and the responder FSM states.
// Optional feature macro: STACK_SCRUB_EN (adds the SCRUB state used by CLEAR).
package stack_pkg;

    // Default geometry shared with the controller.
    localparam int STACK_DW    = 8;
    localparam int STACK_DEPTH = 128;
    localparam int STACK_AW    = 7;

    // Command op-codes carried on cmd_op. Values 5..7 are reserved.
    localparam logic [2:0] OP_PUSH    = 3'd0;
    localparam logic [2:0] OP_POP     = 3'd1;
    localparam logic [2:0] OP_PEEK    = 3'd2;
    localparam logic [2:0] OP_READ_AT = 3'd3;
    localparam logic [2:0] OP_CLEAR   = 3'd4;

    // Responder FSM. The encoding is fixed so a debug probe reads the same
    // numbers in every build; SCRUB only exists when the scrub feature is on.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_RESP  = 2'd2
`ifdef STACK_SCRUB_EN
        ,
        ST_SCRUB = 2'd3
`endif
    } state_t;

    // True for ops that return RAM read data when they succeed.
    function automatic logic op_returns_data(input logic [2:0] op);
        return (op == OP_POP) || (op == OP_PEEK) || (op == OP_READ_AT);
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Single-port synchronous RAM holding the stack entries.
// Read-first: a read of the address being written returns the old word.
// Contents are not reset.
module stack_ram #(
    parameter int DW = 8,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // One-cycle read latency; the write lands after the old word is captured.
    always_ff @(posedge clk) begin
        rdata <= mem[addr];
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/stack_mem_responder.sv
// Memory-side responder for the stack-calculator controller. Owns the stack
// RAM and the stack pointer and executes PUSH/POP/PEEK/READ_AT/CLEAR commands
// received over a valid/ready channel, answering each with one rsp_valid pulse.
// Optional feature macro: STACK_SCRUB_EN (CLEAR also zeroes the whole RAM).
//
// Command channel: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; op/addr/wdata are captured on that edge. cmd_ready
// is high only in IDLE. An initiator seeing cmd_ready low must hold its
// command. Responses have no backpressure: rsp_valid is a one-cycle strobe.
module stack_mem_responder
    import stack_pkg::*;
#(
    parameter int DW    = STACK_DW,
    parameter int DEPTH = STACK_DEPTH,
    parameter int AW    = STACK_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW-1:0] sp,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic [1:0]    dbg_state
);

    localparam logic [AW-1:0] SP_RESET   = AW'(DEPTH - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);

    // Registered state.
    state_t        state_q,     state_d;
    logic [2:0]    op_q,        op_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic [DW-1:0] wdata_q,     wdata_d;
    logic [AW-1:0] sp_q,        sp_d;
    logic [AW:0]   count_q,     count_d;
    logic          empty_q,     empty_d;
    logic          full_q,      full_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q,   rsp_err_d;
    logic          rd_sel_q,    rd_sel_d;
`ifdef STACK_SCRUB_EN
    logic [AW-1:0] scrub_addr_q, scrub_addr_d;
`endif

    // RAM port.
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    // EXEC-cycle decode results.
    logic          exec_err;
    logic          exec_rd;
    logic [AW-1:0] sp_top;

    // The top-of-stack entry sits one above the next free slot.
    assign sp_top = sp_q + 1'b1;

    // RAM access and pointer update for the command held in EXEC (and the
    // scrub sweep). A reset in the same cycle blocks any write being issued.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = sp_q;
        ram_wdata = wdata_q;
        exec_err  = 1'b0;
        exec_rd   = 1'b0;
        sp_d      = sp_q;
        count_d   = count_q;

        if (state_q == ST_EXEC) begin
            case (op_q)
                OP_PUSH: begin
                    ram_addr = sp_q;
                    if (full_q) begin
                        exec_err = 1'b1;
                    end else begin
                        ram_we  = 1'b1;
                        sp_d    = sp_q - 1'b1;
                        count_d = count_q + 1'b1;
                    end
                end
                OP_POP: begin
                    ram_addr = sp_top;
                    if (empty_q) begin
                        exec_err = 1'b1;
                    end else begin
                        exec_rd = 1'b1;
                        sp_d    = sp_top;
                        count_d = count_q - 1'b1;
                    end
                end
                OP_PEEK: begin
                    ram_addr = sp_top;
                    if (empty_q) begin
                        exec_err = 1'b1;
                    end else begin
                        exec_rd = 1'b1;
                    end
                end
                OP_READ_AT: begin
                    // Occupancy is deliberately ignored: any word may be read.
                    ram_addr = addr_q;
                    exec_rd  = 1'b1;
                end
                OP_CLEAR: begin
                    sp_d    = SP_RESET;
                    count_d = '0;
                end
                default: begin
                    exec_err = 1'b1;
                end
            endcase
        end
`ifdef STACK_SCRUB_EN
        else if (state_q == ST_SCRUB) begin
            ram_we    = 1'b1;
            ram_addr  = scrub_addr_q;
            ram_wdata = '0;
        end
`endif

        if (reset) begin
            ram_we = 1'b0;
        end
    end

    // Status flags track the pointer update so they change together with sp.
    assign empty_d = (count_d == '0);
    assign full_d  = (count_d == COUNT_FULL);

    // FSM sequencing: accept in IDLE, access in EXEC, answer in RESP.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rd_sel_d    = rd_sel_q;
`ifdef STACK_SCRUB_EN
        scrub_addr_d = scrub_addr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_err_d = exec_err;
                rd_sel_d  = exec_rd && op_returns_data(op_q);
`ifdef STACK_SCRUB_EN
                if (op_q == OP_CLEAR) begin
                    scrub_addr_d = '0;
                    state_d      = ST_SCRUB;
                end else begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
`else
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
`endif
            end
`ifdef STACK_SCRUB_EN
            ST_SCRUB: begin
                scrub_addr_d = scrub_addr_q + 1'b1;
                if (scrub_addr_q == SP_RESET) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                rsp_err_d = 1'b0;
                rd_sel_d  = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All responder state; reset drops any pending command or response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sp_q        <= SP_RESET;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
`ifdef STACK_SCRUB_EN
            scrub_addr_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sp_q        <= sp_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_sel_q    <= rd_sel_d;
`ifdef STACK_SCRUB_EN
            scrub_addr_q <= scrub_addr_d;
`endif
        end
    end

    stack_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // The RAM output is only presented for successful reads; PUSH, CLEAR and
    // every failed command answer with zero.
    assign rsp_data  = (rsp_valid_q && rd_sel_q) ? ram_rdata : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign sp        = sp_q;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_stack_mem_responder.sv
// Bench for stack_mem_responder: directed command sequences, a stack model
// built from plain arrays, a scoreboard of expected responses and a summary.
module tb_stack_mem_responder;
    import stack_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 7;
    localparam int DEPTH = 128;
`ifdef STACK_SCRUB_EN
    localparam int CLR_LAT = DEPTH + 2;
    localparam bit SCRUB   = 1'b1;
`else
    localparam int CLR_LAT = 2;
    localparam bit SCRUB   = 1'b0;
`endif

    // Clock / reset / DUT signals
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] sp;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    stack_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .sp        (sp),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .dbg_state (dbg_state)
    );

    // Counters
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Stack model: entries by address plus an occupancy count.
    logic [DW-1:0] mdl_mem [DEPTH];
    int            mdl_count = 0;

    // Scoreboard entries: {accept cycle[31:0], latency[7:0], err, data[7:0]}
    localparam int W = 49;
    logic [W-1:0] exp_q[$];

    logic [DW-1:0] last_data = '0;
    logic          last_err  = 1'b0;
    int            last_lat  = 0;
    int            last_acc  = -10;

    function automatic int mdl_sp();
        return (DEPTH - 1 - mdl_count) & (DEPTH - 1);
    endfunction

    // Applies one accepted command to the model and queues its response.
    task automatic model_cmd(input logic [2:0] op, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input int acc);
        logic [DW-1:0] d;
        logic          e;
        int            lat;
        logic [31:0]   acc_v;
        logic [7:0]    lat_v;
        d   = '0;
        e   = 1'b0;
        lat = 2;
        case (op)
            OP_PUSH: begin
                if (mdl_count == DEPTH) e = 1'b1;
                else begin
                    mdl_mem[DEPTH - 1 - mdl_count] = wd;
                    mdl_count++;
                end
            end
            OP_POP: begin
                if (mdl_count == 0) e = 1'b1;
                else begin
                    d = mdl_mem[DEPTH - mdl_count];
                    mdl_count--;
                end
            end
            OP_PEEK: begin
                if (mdl_count == 0) e = 1'b1;
                else d = mdl_mem[DEPTH - mdl_count];
            end
            OP_READ_AT: d = mdl_mem[addr];
            OP_CLEAR: begin
                mdl_count = 0;
                lat = CLR_LAT;
                if (SCRUB) for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
            end
            default: e = 1'b1;
        endcase
        acc_v = acc;
        lat_v = lat[7:0];
        exp_q.push_back({acc_v, lat_v, e, d});
    endtask

    // Compare process: responses against the scoreboard, status against model.
    logic [W-1:0] cmp_e;
    int           cmp_acc;
    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    cmp_e   = exp_q.pop_front();
                    cmp_acc = cmp_e[48:17];
                    last_data = rsp_data;
                    last_err  = rsp_err;
                    last_lat  = cyc - cmp_acc;
                    chk("rsp_data", rsp_data, cmp_e[7:0]);
                    chk("rsp_err", rsp_err, cmp_e[8]);
                    chk("rsp_latency", cyc - cmp_acc, cmp_e[16:9]);
                end
            end
            if (rsp_valid || cmd_ready) begin
                chk("count", count, mdl_count);
                chk("sp", sp, mdl_sp());
                chk("empty", empty, mdl_count == 0);
                chk("full", full, mdl_count == DEPTH);
            end
        end
    end

    // Driver: present a command and hold it until accepted.
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input bit gap_chk);
        int acc;
        int budget;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        budget = 0;
        while (!cmd_ready && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge clk);
        if (gap_chk) chk("b2b_gap", acc - last_acc, 3);
        last_acc = acc;
        model_cmd(op, addr, wd, acc);
    endtask

    // Drop cmd_valid and wait for every outstanding response.
    task automatic wait_done();
        int budget;
        @(negedge clk);
        cmd_valid = 1'b0;
        budget = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        chk("rsp_outstanding", exp_q.size(), 0);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        issue(op, addr, wd, 1'b0);
        wait_done();
    endtask

    logic [DW-1:0] saved;

    initial begin
        // Reset values
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_sp", sp, 7'h7F);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(negedge clk);
        reset = 1'b0;

        // Three pushes, then PEEK
        cmd(OP_PUSH, '0, 8'h11); chk("push1_err", last_err, 0);
        cmd(OP_PUSH, '0, 8'h22); chk("push2_err", last_err, 0);
        cmd(OP_PUSH, '0, 8'h33); chk("push3_err", last_err, 0);
        chk("push3_count", count, 3);
        chk("push3_sp", sp, 7'h7C);
        cmd(OP_PEEK, '0, '0);
        chk("peek_data", last_data, 8'h33);
        chk("peek_latency", last_lat, 2);

        // Pop to empty and one past it
        cmd(OP_POP, '0, '0); chk("pop1_data", last_data, 8'h33);
        cmd(OP_POP, '0, '0); chk("pop2_data", last_data, 8'h22);
        cmd(OP_POP, '0, '0); chk("pop3_data", last_data, 8'h11);
        chk("pop3_empty", empty, 1);
        chk("pop3_sp", sp, 7'h7F);
        cmd(OP_POP, '0, '0);
        chk("pop_empty_err", last_err, 1);
        chk("pop_empty_data", last_data, 0);
        chk("pop_empty_count", count, 0);
        cmd(OP_PEEK, '0, '0);
        chk("peek_empty_err", last_err, 1);

        // Reserved op
        cmd(3'd6, '0, 8'hFF);
        chk("reserved_err", last_err, 1);

        // Fill completely
        for (int i = 0; i < DEPTH; i++) cmd(OP_PUSH, '0, DW'(i));
        chk("fill_full", full, 1);
        chk("fill_count", count, 128);
        cmd(OP_PUSH, '0, 8'hAA);
        chk("push_full_err", last_err, 1);
        chk("push_full_data", last_data, 0);
        cmd(OP_READ_AT, 7'h00, '0); chk("read_at_0", last_data, 8'd127);
        cmd(OP_READ_AT, 7'h7F, '0); chk("read_at_7f", last_data, 8'd0);
        cmd(OP_PEEK, '0, '0);       chk("peek_full", last_data, 8'd127);

        // CLEAR behaviour
        cmd(OP_CLEAR, '0, '0);
        chk("clear_latency", last_lat, CLR_LAT);
        cmd(OP_PUSH, '0, 8'h55);
        cmd(OP_CLEAR, '0, '0);
        chk("clear_err", last_err, 0);
        chk("clear_count", count, 0);
        chk("clear_empty", empty, 1);
        cmd(OP_READ_AT, 7'h7F, '0);
        chk("clear_ram", last_data, SCRUB ? 8'h00 : 8'h55);

        // Back-to-back pushes with cmd_valid held high
        issue(OP_PUSH, '0, 8'hA0, 1'b0);
        issue(OP_PUSH, '0, 8'hA1, 1'b1);
        issue(OP_PUSH, '0, 8'hA2, 1'b1);
        issue(OP_PUSH, '0, 8'hA3, 1'b1);
        wait_done();
        chk("b2b_count", count, 4);
        for (int i = 0; i < 4; i++) cmd(OP_POP, '0, '0);
        chk("b2b_last_pop", last_data, 8'hA0);

        // Reset during the EXEC cycle of a PUSH at count=2
        cmd(OP_CLEAR, '0, '0);
        cmd(OP_PUSH, '0, 8'h01);
        cmd(OP_PUSH, '0, 8'h02);
        saved = mdl_mem[125];
        issue(OP_PUSH, '0, 8'hEE, 1'b0);
        @(negedge clk);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        exp_q.delete();
        mdl_count = 0;
        mdl_mem[125] = saved;
        @(posedge clk);
        #1;
        chk("midrst_state", dbg_state, ST_IDLE);
        chk("midrst_count", count, 0);
        chk("midrst_sp", sp, 7'h7F);
        chk("midrst_rsp_valid", rsp_valid, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_no_rsp", rsp_valid, 0);
        cmd(OP_READ_AT, 7'h7D, '0);
        chk("midrst_ram_kept", last_data, saved);
        cmd(OP_PUSH, '0, 8'h77);
        chk("after_rst_count", count, 1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
